// File: rtl/stack_mem_pkg.sv
// Shared definitions for the CPU-side memory controller: FSM state encoding
// and the default bus widths the CPU core is built with.
package stack_mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

endpackage

// File: rtl/sp_ram.sv
// Synchronous single-port RAM with registered read data, written so synthesis
// maps it onto block RAM (no reset on the array or the read register).
module sp_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 16
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/stack_mem_ctrl.sv
// Memory controller between the CPU bus and on-chip RAM: samples one request
// in IDLE, inserts WAIT_STATES wait cycles, accesses RAM, then strobes ready.
module stack_mem_ctrl
    import stack_mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              memory_w,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] in_data,
    output logic              memory_ready,
    output logic              mem_busy,
    output logic              mem_error
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    mem_state_t        state;
    mem_state_t        state_nxt;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_zero;
    logic              out_of_range;
    logic              ram_en;
    logic [DATA_W-1:0] ram_rdata;

    assign out_of_range = (addr_q >> DEPTH_LOG2) != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_req) state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (wait_cnt == 4'd1) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rd_zero masks the RAM read register after reset and after out-of-range
    // reads, so in_data only ever shows data from a completed in-range read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rd_zero  <= 1'b1;
        end else begin
            if (state == IDLE && mem_req) begin
                wait_cnt <= WAIT_LOAD;
                addr_q   <= addr;
                we_q     <= memory_w;
                wdata_q  <= out_data;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == ACCESS && !we_q) begin
                rd_zero <= out_of_range;
            end
        end
    end

    always_comb begin
        memory_ready = (state == DONE);
        mem_busy     = (state != IDLE);
        mem_error    = (state == DONE) && out_of_range;
        ram_en       = (state == ACCESS) && !out_of_range;
    end

    assign in_data = rd_zero ? '0 : ram_rdata;

    sp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .addr  (addr_q[DEPTH_LOG2-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Bench for stack_mem_ctrl: a transaction-level model checked every cycle plus
// directed transactions with literal expectations, on 2- and 0-wait instances.
module tb_stack_mem_ctrl;
    import stack_mem_pkg::*;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req = 1'b0;
    logic        memory_w = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] out_data = '0;
    logic [15:0] in_data;
    logic        memory_ready;
    logic        mem_busy;
    logic        mem_error;

    logic        req0 = 1'b0;
    logic        w0 = 1'b0;
    logic [15:0] a0 = '0;
    logic [15:0] d0 = '0;
    logic [15:0] rd0;
    logic        rdy0;
    logic        busy0;
    logic        err0;

    always #5 clk = ~clk;

    stack_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .memory_w(memory_w), .addr(addr),
        .out_data(out_data), .in_data(in_data), .memory_ready(memory_ready),
        .mem_busy(mem_busy), .mem_error(mem_error)
    );

    stack_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_req(req0), .memory_w(w0), .addr(a0),
        .out_data(d0), .in_data(rd0), .memory_ready(rdy0),
        .mem_busy(busy0), .mem_error(err0)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: a request accepted at edge k completes (DONE visible)
    // after edge k+1+WS; the controller accepts again two edges after that.
    int          m_now = 0;
    int          req_edge = -10;
    int          done_edge = -10;
    logic        m_w = 1'b0;
    logic [15:0] m_a = '0;
    logic [15:0] m_d = '0;
    logic [15:0] mem_model [int];
    logic [15:0] exp_in = '0;
    bit          exp_known = 1'b1;
    bit          chk_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_edge  = m_now - 10;
            done_edge = m_now - 10;
            exp_in    = '0;
            exp_known = 1'b1;
        end else begin
            m_now++;
            if (m_now == done_edge) begin
                if (m_a >= 16'h0400) begin
                    if (!m_w) begin
                        exp_in    = '0;
                        exp_known = 1'b1;
                    end
                end else if (m_w) begin
                    mem_model[int'(m_a[9:0])] = m_d;
                end else if (mem_model.exists(int'(m_a[9:0]))) begin
                    exp_in    = mem_model[int'(m_a[9:0])];
                    exp_known = 1'b1;
                end else begin
                    exp_known = 1'b0;
                end
            end
            if (mem_req && m_now >= done_edge + 2) begin
                req_edge  = m_now;
                done_edge = m_now + 1 + WS;
                m_w = memory_w;
                m_a = addr;
                m_d = out_data;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("memory_ready", 32'(memory_ready), 32'(m_now == done_edge));
            checkOutput("mem_busy", 32'(mem_busy), 32'(m_now >= req_edge && m_now <= done_edge));
            checkOutput("mem_error", 32'(mem_error), 32'(m_now == done_edge && m_a >= 16'h0400));
            if (exp_known) checkOutput("in_data", 32'(in_data), 32'(exp_in));
        end
    end

    task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [15:0] d,
                                 output int lat, output logic [15:0] rd, output logic err);
        int req_cyc;
        bit seen;
        @(posedge clk); #2;
        mem_req = 1'b1; memory_w = w; addr = a; out_data = d;
        req_cyc = m_now;
        @(posedge clk); #2;
        mem_req = 1'b0; memory_w = ~w; addr = ~a; out_data = ~d;
        seen = 1'b0; lat = -1; rd = '0; err = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (memory_ready) begin
                seen = 1'b1;
                lat  = m_now - req_cyc;
                rd   = in_data;
                err  = mem_error;
            end
        end
        if (!seen) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic zeroWaitTxn(input logic w, input logic [15:0] a, input logic [15:0] d,
                               output logic [15:0] rd);
        @(posedge clk); #2;
        req0 = 1'b1; w0 = w; a0 = a; d0 = d;
        @(negedge clk);
        checkOutput("zw_busy_c", 32'(busy0), 32'd0);
        @(posedge clk); #2;
        req0 = 1'b0; a0 = ~a; d0 = ~d;
        @(negedge clk);
        checkOutput("zw_busy_c1", 32'(busy0), 32'd1);
        checkOutput("zw_ready_c1", 32'(rdy0), 32'd0);
        @(negedge clk);
        checkOutput("zw_busy_c2", 32'(busy0), 32'd1);
        checkOutput("zw_ready_c2", 32'(rdy0), 32'd1);
        rd = rd0;
        @(negedge clk);
        checkOutput("zw_busy_c3", 32'(busy0), 32'd0);
        checkOutput("zw_ready_c3", 32'(rdy0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        err;
        int          last_rdy;
        int          n_rdy;

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        applyStimulus(1'b1, 16'h0000, 16'h5A5A, lat, rd, err);
        applyStimulus(1'b0, 16'h0000, 16'h0000, lat, rd, err);
        checkOutput("seed_read", 32'(rd), 32'h5A5A);

        // Reset in the middle of a write's wait period must abort it cleanly.
        @(posedge clk); #2;
        mem_req = 1'b1; memory_w = 1'b1; addr = 16'h0010; out_data = 16'hBEEF;
        @(posedge clk); #2;
        mem_req = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_ready", 32'(memory_ready), 32'd0);
            checkOutput("rst_busy", 32'(mem_busy), 32'd0);
            checkOutput("rst_error", 32'(mem_error), 32'd0);
            checkOutput("rst_in_data", 32'(in_data), 32'd0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0010, 16'h0000, lat, rd, err);
        checkOutput("rst_write_aborted", 32'(rd != 16'hBEEF), 32'd1);

        applyStimulus(1'b0, 16'h0000, 16'h0000, lat, rd, err);
        applyStimulus(1'b1, 16'h0005, 16'h1234, lat, rd, err);
        checkOutput("wr_latency", 32'(lat), 32'd4);
        checkOutput("wr_in_data_held", 32'(rd), 32'h5A5A);
        applyStimulus(1'b0, 16'h0005, 16'h0000, lat, rd, err);
        checkOutput("rd_latency", 32'(lat), 32'd4);
        checkOutput("rd_data", 32'(rd), 32'h1234);
        checkOutput("rd_error", 32'(err), 32'd0);

        applyStimulus(1'b1, 16'h0400, 16'hAAAA, lat, rd, err);
        checkOutput("oor_wr_error", 32'(err), 32'd1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, lat, rd, err);
        checkOutput("oor_no_alias", 32'(rd), 32'h5A5A);
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, lat, rd, err);
        checkOutput("oor_rd_data", 32'(rd), 32'h0000);
        checkOutput("oor_rd_error", 32'(err), 32'd1);

        applyStimulus(1'b1, 16'h03FF, 16'h00FF, lat, rd, err);
        applyStimulus(1'b0, 16'h03FF, 16'h0000, lat, rd, err);
        checkOutput("raw_data", 32'(rd), 32'h00FF);
        applyStimulus(1'b0, 16'h0000, 16'h0000, lat, rd, err);
        checkOutput("wrap_data", 32'(rd), 32'h5A5A);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(i), 16'h1000 + 16'(i), lat, rd, err);
        end

        // Request held high while the address walks: only IDLE samples count.
        @(posedge clk); #2;
        mem_req = 1'b1; memory_w = 1'b0;
        last_rdy = -1;
        n_rdy = 0;
        for (int i = 0; i < 26; i++) begin
            addr = 16'h0100 + 16'(i % 16);
            @(negedge clk);
            if (memory_ready) begin
                if (last_rdy >= 0) checkOutput("ready_spacing", 32'(m_now - last_rdy), 32'(3 + WS));
                last_rdy = m_now;
                n_rdy++;
            end
            @(posedge clk); #2;
        end
        mem_req = 1'b0;
        checkOutput("hold_ready_count", 32'(n_rdy), 32'd5);
        repeat (8) @(posedge clk);

        zeroWaitTxn(1'b1, 16'h0003, 16'h0042, rd);
        zeroWaitTxn(1'b0, 16'h0003, 16'h0000, rd);
        checkOutput("zw_rd_data", 32'(rd), 32'h0042);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
